vend_session_arbiter: RTL and testbench
=======================================

# vend_session_arbiter

Shares one vending core (`vending_machine_15072024`: `clk`, `rst`, `in[1:0]`, `out`, `change[1:0]`) among N front-panel coin slots. Grants the core to one requester at a time, round-robin. Forwards that requester's coin codes to the core and returns the dispense result. Aborts stalled or abandoned sessions by clearing the core's partial credit. Sits between the panel requesters and the single core instance.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 16: consecutive coin-less cycles in a session before abort (1..255).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: requester i wants a session; held high until its `done`/`abort`.
- `coin` in 2*N_REQ: coin code of slot i on bits [2i+1:2i]. 00 = none, 01 = 5, 10 = 10, 11 = illegal.
- `grant` out N_REQ: one-hot, registered; slot currently owning the core.
- `busy` out 1: a session or abort is in progress.
- `done` out 1: one-cycle pulse, purchase completed.
- `done_id` out clog2(N_REQ): slot index for `done`/`abort`; held until the next event.
- `done_change` out 2: core change captured with `done`; held.
- `abort` out 1: one-cycle pulse, session aborted.
- `vm_in` out 2: registered coin code to the core.
- `vm_out` in 1: core dispense pulse.
- `vm_change` in 2: core change, valid with `vm_out`.
- `vm_rst` out 1: one-cycle pulse clearing core credit on abort.

## Operation
- States: IDLE, SERVE, DONE, ABORT.
- Reset: state IDLE, pointer 0, timer 0. All outputs 0: `grant`, `busy`, `done`, `abort`, `done_id`, `done_change`, `vm_in`, `vm_rst`.
- IDLE:
  - If `req` != 0, pick the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Next cycle: `grant` one-hot for that slot, `busy`=1, timer 0, go to SERVE.
  - If `req` = 0, stay in IDLE with `vm_in`=00.
- SERVE:
  - Each cycle `vm_in` <= the granted slot's coin. Code 11 is forwarded as 00 and counts as no coin.
  - The timer increments on each coin-less cycle and clears on any valid coin.
  - `vm_out`=1: capture `vm_change` into `done_change`, index into `done_id`, go to DONE.
  - Else granted `req` low, or timer reaches TIMEOUT: go to ABORT.
- DONE (one cycle):
  - `done`=1, `grant`=0, `vm_in`=00.
  - Pointer <= granted index + 1 (mod N_REQ).
  - Go to IDLE.
- ABORT (one cycle):
  - `abort`=1, `vm_rst`=1, `grant`=0, `vm_in`=00, `done_id` = aborted slot.
  - Pointer advances as in DONE.
  - Go to IDLE.
- Simultaneous `vm_out` with timeout or `req` drop: `vm_out` wins and the purchase completes.
- Non-granted slots' coins are ignored entirely.
- `rst` mid-session forces reset values on the next edge. `vm_rst` is not pulsed; the core shares system `rst`.
- `vm_out` seen outside SERVE is ignored.

## Timing
- `req` to `grant`: 1 cycle.
- `coin` to `vm_in`: 1 cycle.
- `vm_out` to `done`: 1 cycle.
- Minimum gap between sessions is 1 idle cycle (DONE/ABORT state, then IDLE arbitration): `grant` low for at least 2 cycles.
- Timeout: abort state entered on the edge where the coin-less count equals TIMEOUT. `abort` is visible TIMEOUT+1 cycles after the last valid coin was sampled.
- `done`, `abort`, `vm_rst` are exactly one cycle wide and never coincide with `grant` != 0.

## Structure
- Package `vend_pkg` holds:
  - coin code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10;
  - PRICE=15;
  - the state enum (IDLE/SERVE/DONE/ABORT).
- Sub-module `rr_arbiter`: combinational round-robin picker taking `req` and the pointer, producing a one-hot choice and its index. The pointer register stays in the parent.

## Test plan
- Slot 0: `req`=0001, coins 01 then 10, core pulses `vm_out` with change 00 → `done` one cycle, `done_id`=0, `done_change`=00, `grant` returns to 0000.
- Slot 2: coins 10, 10, core returns change 01 → `done_change`=01, `done_id`=2; `vm_in` shows 10, 10 each one cycle after `coin`.
- `req`=1111 held, each slot paying 10+5 → grants in order 0001, 0010, 0100, 1000, then 0001 again. A non-granted slot's coins never appear on `vm_in`.
- Slot 1 granted, no coins for 16 cycles (TIMEOUT=16) → `abort` and `vm_rst` pulse together, `done_id`=1, next grant goes to slot 2 if requesting.
- Granted slot drives coin 11 for 5 cycles then drops `req` → `vm_in` stays 00 throughout, then `abort`. The same cycle as `vm_out`=1 with `req` drop → `done`, not `abort`.
- `rst` asserted mid-SERVE after one coin → next cycle all outputs 0, state IDLE, pointer 0, `vm_rst` stays 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants, coin encodings and FSM state type for the vending session arbiter.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam int unsigned PRICE   = 15;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_e;

  // Only 5 and 10 count as money; 11 is treated like an empty slot.
  function automatic logic coin_valid(input logic [1:0] code);
    return (code == COIN_5) || (code == COIN_10);
  endfunction

endpackage

// File: rtl/vend_session_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import vend_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick_c,
  output logic [IW-1:0]    pick_idx_c,
  output logic             pick_valid_c
);

  int unsigned slot;

  always_comb begin
    pick_c       = '0;
    pick_idx_c   = '0;
    pick_valid_c = 1'b0;
    slot         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      slot = 32'(ptr) + k;
      if (slot >= N_REQ) slot = slot - N_REQ;
      if (!pick_valid_c && req[IW'(slot)]) begin
        pick_valid_c = 1'b1;
        pick_idx_c   = IW'(slot);
      end
    end
    pick_c[pick_idx_c] = pick_valid_c;
  end

endmodule

// File: rtl/vend_session_arbiter.sv
// Time-shares one vending core among N_REQ coin slots with round-robin grants,
// coin forwarding, completion reporting and timeout/abandon aborts.
module vend_session_arbiter
  import vend_pkg::*;
#(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned TIMEOUT = 16,
  localparam int unsigned IW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] coin,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      done_id,
  output logic [1:0]         done_change,
  output logic               abort,
  output logic [1:0]         vm_in,
  input  logic               vm_out,
  input  logic [1:0]         vm_change,
  output logic               vm_rst
);

  state_e state, state_d;

  logic [IW-1:0]      ptr, ptr_d;
  logic [IW-1:0]      gidx, gidx_d;
  logic [TIMER_W-1:0] timer, timer_d;

  logic [N_REQ-1:0] grant_d;
  logic             busy_d, done_d, abort_d, vm_rst_d;
  logic [IW-1:0]    done_id_d;
  logic [1:0]       done_change_d, vm_in_d;

  logic [N_REQ-1:0] pick_c;
  logic [IW-1:0]    pick_idx_c;
  logic             pick_valid_c;
  logic [1:0]       gcoin_c;
  logic             gcoin_ok_c;
  logic             timed_out_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req          (req),
    .ptr          (ptr),
    .pick_c       (pick_c),
    .pick_idx_c   (pick_idx_c),
    .pick_valid_c (pick_valid_c)
  );

  // Only the granted slot's coin lane is ever looked at.
  assign gcoin_c     = coin[{gidx, 1'b0} +: 2];
  assign gcoin_ok_c  = coin_valid(gcoin_c);
  assign timed_out_c = (timer == TIMER_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; a dispense pulse beats both timeout and req drop.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (pick_valid_c) state_d = SERVE;
      SERVE: begin
        if (vm_out)                          state_d = DONE;
        else if (!req[gidx] || timed_out_c)  state_d = ABORT;
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of registered outputs and datapath
  always_comb begin
    grant_d       = '0;
    busy_d        = (state_d != IDLE);
    done_d        = 1'b0;
    abort_d       = 1'b0;
    vm_rst_d      = 1'b0;
    vm_in_d       = COIN_NONE;
    done_id_d     = done_id;
    done_change_d = done_change;
    gidx_d        = gidx;
    timer_d       = timer;
    ptr_d         = ptr;
    case (state)
      IDLE: begin
        if (pick_valid_c) begin
          grant_d = pick_c;
          gidx_d  = pick_idx_c;
          timer_d = '0;
        end
      end
      SERVE: begin
        if (state_d == SERVE) begin
          grant_d = grant;
          vm_in_d = gcoin_ok_c ? gcoin_c : COIN_NONE;
          timer_d = gcoin_ok_c ? '0 : timer + TIMER_W'(1);
        end else if (state_d == DONE) begin
          done_d        = 1'b1;
          done_id_d     = gidx;
          done_change_d = vm_change;
        end else begin
          abort_d   = 1'b1;
          vm_rst_d  = 1'b1;
          done_id_d = gidx;
        end
      end
      DONE, ABORT: begin
        ptr_d   = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
        timer_d = '0;
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
      vm_rst      <= 1'b0;
      vm_in       <= COIN_NONE;
      done_id     <= '0;
      done_change <= '0;
      gidx        <= '0;
      timer       <= '0;
      ptr         <= '0;
    end else begin
      grant       <= grant_d;
      busy        <= busy_d;
      done        <= done_d;
      abort       <= abort_d;
      vm_rst      <= vm_rst_d;
      vm_in       <= vm_in_d;
      done_id     <= done_id_d;
      done_change <= done_change_d;
      gidx        <= gidx_d;
      timer       <= timer_d;
      ptr         <= ptr_d;
    end
  end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed bench for vend_session_arbiter; the bench plays the vending core.
module tb_vend_session_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] coin = '0;
  logic [3:0] grant;
  logic       busy, done, abort, vm_rst, vm_out;
  logic [1:0] done_id, done_change, vm_in, vm_change;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_g [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int         exp_i [5] = '{3, 0, 1, 2, 3};

  always #5 clk = ~clk;

  vend_session_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .coin        (coin),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .done_change (done_change),
    .abort       (abort),
    .vm_in       (vm_in),
    .vm_out      (vm_out),
    .vm_change   (vm_change),
    .vm_rst      (vm_rst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] coins(input int g, input logic [1:0] gc, input logic [1:0] oc);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[2*i +: 2] = (i == g) ? gc : oc;
    return v;
  endfunction

  initial begin
    vm_out    = 1'b0;
    vm_change = 2'b00;

    // reset values
    tick(); tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_done_change", 32'(done_change), 0);
    chk("rst_vm_in", 32'(vm_in), 0);
    chk("rst_vm_rst", 32'(vm_rst), 0);
    rst = 1'b0;

    // slot 0: 5 + 10, no change
    req = 4'b0001; tick();
    chk("s0_grant", 32'(grant), 32'b0001);
    chk("s0_busy", 32'(busy), 1);
    coin = 8'b0000_0001; tick();
    chk("s0_vm_in_5", 32'(vm_in), 32'b01);
    coin = 8'b0000_0010; tick();
    chk("s0_vm_in_10", 32'(vm_in), 32'b10);
    coin = '0; vm_out = 1'b1; vm_change = 2'b00; tick();
    chk("s0_done", 32'(done), 1);
    chk("s0_done_id", 32'(done_id), 0);
    chk("s0_done_change", 32'(done_change), 0);
    chk("s0_grant_off", 32'(grant), 0);
    chk("s0_vm_in_off", 32'(vm_in), 0);
    vm_out = 1'b0; req = '0; tick();
    chk("s0_done_pulse", 32'(done), 0);
    chk("s0_busy_off", 32'(busy), 0);

    // slot 2: 10 + 10, change 5; slot 0 coins ignored
    req = 4'b0100; tick();
    chk("s2_grant", 32'(grant), 32'b0100);
    coin = 8'b0010_0001; tick();
    chk("s2_vm_in_a", 32'(vm_in), 32'b10);
    tick();
    chk("s2_vm_in_b", 32'(vm_in), 32'b10);
    coin = '0; vm_out = 1'b1; vm_change = 2'b01; tick();
    chk("s2_done", 32'(done), 1);
    chk("s2_done_id", 32'(done_id), 2);
    chk("s2_done_change", 32'(done_change), 32'b01);
    vm_out = 1'b0; req = '0; tick();

    // all slots requesting: round-robin from pointer 3
    for (int k = 0; k < 5; k++) begin
      req = 4'b1111; coin = '0; tick();
      chk("rr_grant", 32'(grant), 32'(exp_g[k]));
      coin = coins(exp_i[k], 2'b10, 2'b01); tick();
      chk("rr_vm_in_10", 32'(vm_in), 32'b10);
      coin = coins(exp_i[k], 2'b01, 2'b10); tick();
      chk("rr_vm_in_5", 32'(vm_in), 32'b01);
      coin = '0; vm_out = 1'b1; vm_change = 2'b00; tick();
      chk("rr_done", 32'(done), 1);
      chk("rr_done_id", 32'(done_id), 32'(exp_i[k]));
      chk("rr_grant_off", 32'(grant), 0);
      vm_out = 1'b0; tick();
      chk("rr_gap_grant", 32'(grant), 0);
      chk("rr_gap_done", 32'(done), 0);
    end
    req = '0;

    // slot 1 timeout; slot 2 also requesting
    req = 4'b0110; tick();
    chk("to_grant", 32'(grant), 32'b0010);
    repeat (16) tick();
    chk("to_not_yet", 32'(abort), 0);
    chk("to_grant_held", 32'(grant), 32'b0010);
    tick();
    chk("to_abort", 32'(abort), 1);
    chk("to_vm_rst", 32'(vm_rst), 1);
    chk("to_done_id", 32'(done_id), 1);
    chk("to_grant_off", 32'(grant), 0);
    chk("to_done_quiet", 32'(done), 0);
    tick();
    chk("to_abort_pulse", 32'(abort), 0);
    chk("to_vm_rst_pulse", 32'(vm_rst), 0);
    chk("to_gap_grant", 32'(grant), 0);
    tick();
    chk("to_next_grant", 32'(grant), 32'b0100);

    // slot 2 drives illegal code then walks away
    req = 4'b0100; coin = 8'b0011_0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ill_vm_in", 32'(vm_in), 0);
    end
    req = '0; coin = '0; tick();
    chk("drop_abort", 32'(abort), 1);
    chk("drop_done_id", 32'(done_id), 2);
    chk("drop_vm_rst", 32'(vm_rst), 1);
    tick();
    chk("drop_abort_pulse", 32'(abort), 0);

    // stray dispense pulse while idle
    vm_out = 1'b1; vm_change = 2'b11; tick();
    chk("idle_vm_out_done", 32'(done), 0);
    chk("idle_vm_out_change", 32'(done_change), 0);
    vm_out = 1'b0;

    // slot 3: dispense in the same cycle req drops
    req = 4'b1000; tick();
    chk("race_grant", 32'(grant), 32'b1000);
    coin = 8'b0100_0000; tick();
    chk("race_vm_in", 32'(vm_in), 32'b01);
    coin = '0; req = '0; vm_out = 1'b1; vm_change = 2'b10; tick();
    chk("race_done", 32'(done), 1);
    chk("race_abort", 32'(abort), 0);
    chk("race_vm_rst", 32'(vm_rst), 0);
    chk("race_done_id", 32'(done_id), 3);
    chk("race_done_change", 32'(done_change), 32'b10);
    vm_out = 1'b0; tick();

    // short slot-0 session to move the pointer to 1
    req = 4'b0001; tick();
    chk("p_grant", 32'(grant), 32'b0001);
    vm_out = 1'b1; vm_change = 2'b01; tick();
    chk("p_done", 32'(done), 1);
    vm_out = 1'b0; req = '0; tick();

    // reset in the middle of a slot-2 session
    req = 4'b0100; tick();
    chk("mr_grant", 32'(grant), 32'b0100);
    coin = 8'b0010_0000; tick();
    chk("mr_vm_in", 32'(vm_in), 32'b10);
    rst = 1'b1; tick();
    chk("mr_grant_rst", 32'(grant), 0);
    chk("mr_busy_rst", 32'(busy), 0);
    chk("mr_vm_in_rst", 32'(vm_in), 0);
    chk("mr_vm_rst", 32'(vm_rst), 0);
    chk("mr_abort", 32'(abort), 0);
    chk("mr_done_id", 32'(done_id), 0);
    chk("mr_done_change", 32'(done_change), 0);
    rst = 1'b0; coin = '0; req = 4'b1111; tick();
    chk("mr_ptr_zero", 32'(grant), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
